// File: rtl/bp_me_pkg.sv
// bp_me_pkg: BedRock mem header types, pump modes and beat-count helper shared by the inbound stream pump.
package bp_me_pkg;

    localparam int paddr_width_gp = 40;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'd0,
        e_bedrock_msg_size_2   = 3'd1,
        e_bedrock_msg_size_4   = 3'd2,
        e_bedrock_msg_size_8   = 3'd3,
        e_bedrock_msg_size_16  = 3'd4,
        e_bedrock_msg_size_32  = 3'd5,
        e_bedrock_msg_size_64  = 3'd6,
        e_bedrock_msg_size_128 = 3'd7
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        logic [7:0]                payload;
        bp_bedrock_msg_size_e      size;
        logic [paddr_width_gp-1:0] addr;
        logic [3:0]                subop;
        bp_bedrock_mem_type_e      msg_type;
    } bp_bedrock_mem_header_s;

    typedef enum logic [1:0] {
        e_pump_1to1,
        e_pump_1toN,
        e_pump_Nto1
    } bp_me_pump_mode_e;

    typedef enum logic {
        e_pump_idle,
        e_pump_stream
    } bp_me_pump_state_e;

    // Beats needed for 2^size bytes, floored at one beat and capped at a full block.
    function automatic int bp_me_num_beats(input logic [2:0] size_i, input int offset_i, input int max_log2_i);
        int l;
        l = int'(size_i) - offset_i;
        l = (l < 0) ? 0 : (l > max_log2_i) ? max_log2_i : l;
        return 1 << l;
    endfunction

endpackage

// File: rtl/bp_me_stream_wraparound.sv
// bp_me_stream_wraparound: combinational per-beat address from the critical address, beat count and message length.
module bp_me_stream_wraparound
    import bp_me_pkg::*;
#(
    parameter int paddr_width_p   = paddr_width_gp,
    parameter int stream_offset_p = 3,
    parameter int cnt_width_p     = 3
) (
    input  logic [paddr_width_p-1:0] base_addr_i,
    input  logic [cnt_width_p-1:0]   cnt_i,
    input  logic [cnt_width_p-1:0]   last_cnt_i,
    input  logic                     wrap_i,
    output logic [paddr_width_p-1:0] addr_o
);

    logic [cnt_width_p-1:0] crit_idx, step_idx, idx;

    // last_cnt_i is num_beats-1, a mask of the index bits that move within the message.
    assign crit_idx = base_addr_i[stream_offset_p +: cnt_width_p];
    assign step_idx = wrap_i ? crit_idx + cnt_i : cnt_i;
    assign idx      = (step_idx & last_cnt_i) | (crit_idx & ~last_cnt_i);

    always_comb begin
        addr_o = base_addr_i;
        addr_o[stream_offset_p +: cnt_width_p] = idx;
    end

endmodule

// File: rtl/bp_me_stream_pump_in_gen.sv
// bp_me_stream_pump_in_gen: buffers an inbound BedRock mem stream and presents per-beat header, address,
// data and beat index to a consumer FSM, handling 1:1, 1:N and N:1 beat conversion with sticky error detection.
module bp_me_stream_pump_in_gen
    import bp_me_pkg::*;
#(
    parameter int stream_data_width_p = 64,
    parameter int block_width_p       = 512,
    parameter int fifo_els_p          = 2,
    parameter int mem_stream_mask_p   = 0,
    parameter int fsm_stream_mask_p   = mem_stream_mask_p,
    parameter int wrap_mode_p         = 1,
    localparam int hdr_width_lp       = $bits(bp_bedrock_mem_header_s),
    localparam int stream_words_lp    = block_width_p / stream_data_width_p,
    localparam int cnt_width_lp       = (stream_words_lp > 1) ? $clog2(stream_words_lp) : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [hdr_width_lp-1:0]        mem_header_i,
    input  logic [stream_data_width_p-1:0] mem_data_i,
    input  logic                           mem_v_i,
    input  logic                           mem_last_i,
    output logic                           mem_ready_and_o,
    output logic [hdr_width_lp-1:0]        fsm_base_header_o,
    output logic [paddr_width_gp-1:0]      fsm_addr_o,
    output logic [stream_data_width_p-1:0] fsm_data_o,
    output logic                           fsm_v_o,
    input  logic                           fsm_yumi_i,
    output logic [cnt_width_lp-1:0]        fsm_cnt_o,
    output logic                           stream_new_o,
    output logic                           stream_done_o,
    output logic                           error_o
);

    localparam int stream_offset_lp  = $clog2(stream_data_width_p / 8);
    localparam int beats_log2_lp     = $clog2(stream_words_lp);
    localparam int ptr_width_lp      = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int count_width_lp    = ptr_width_lp + 1;
    localparam logic [15:0] mem_mask_lp = 16'(mem_stream_mask_p);
    localparam logic [15:0] fsm_mask_lp = 16'(fsm_stream_mask_p);

    bp_bedrock_mem_header_s          hdr_mem_q [fifo_els_p];
    logic [stream_data_width_p-1:0]  data_mem_q [fifo_els_p];
    logic [fifo_els_p-1:0]           last_mem_q;
    logic [ptr_width_lp-1:0]         rptr_q, rptr_d, wptr_q, wptr_d;
    logic [count_width_lp-1:0]       count_q, count_d;
    logic                            push, pop, fifo_v, fifo_last;
    bp_bedrock_mem_header_s          fifo_hdr;

    assign mem_ready_and_o = count_q != count_width_lp'(fifo_els_p);
    assign push            = mem_v_i & mem_ready_and_o;
    assign fifo_v          = count_q != '0;
    assign fifo_hdr        = hdr_mem_q[rptr_q];
    assign fifo_last       = last_mem_q[rptr_q];
    assign fsm_data_o      = data_mem_q[rptr_q];

    always_comb begin
        wptr_d  = !push ? wptr_q : (wptr_q == ptr_width_lp'(fifo_els_p - 1)) ? '0 : wptr_q + 1'b1;
        rptr_d  = !pop ? rptr_q : (rptr_q == ptr_width_lp'(fifo_els_p - 1)) ? '0 : rptr_q + 1'b1;
        count_d = count_q + count_width_lp'(push) - count_width_lp'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            hdr_mem_q[wptr_q]  <= bp_bedrock_mem_header_s'(mem_header_i);
            data_mem_q[wptr_q] <= mem_data_i;
            last_mem_q[wptr_q] <= mem_last_i;
        end
    end

    bp_me_pump_state_e         state_q, state_d;
    logic [cnt_width_lp-1:0]   cnt_q, cnt_d, last_cnt;
    logic                      err_q, err_d;
    bp_bedrock_mem_header_s    hdr_q, hdr_d, cur_hdr;
    logic [cnt_width_lp:0]     nb;
    logic                      fsm_multi, mem_multi, is_last, mem_final, cnt_up, restart;
    bp_me_pump_mode_e          mode;

    // In IDLE the header (and so the critical address) bypasses straight from the FIFO head.
    always_comb begin
        cur_hdr   = (state_q == e_pump_stream) ? hdr_q : fifo_hdr;
        nb        = (cnt_width_lp + 1)'(bp_me_num_beats(cur_hdr.size, stream_offset_lp, beats_log2_lp));
        fsm_multi = |nb[cnt_width_lp:1] & fsm_mask_lp[cur_hdr.msg_type];
        mem_multi = |nb[cnt_width_lp:1] & mem_mask_lp[cur_hdr.msg_type];
        mode      = (fsm_multi & !mem_multi) ? e_pump_1toN : (!fsm_multi & mem_multi) ? e_pump_Nto1 : e_pump_1to1;
        last_cnt  = (fsm_multi | mem_multi) ? nb[cnt_width_lp-1:0] - 1'b1 : '0;
        is_last   = cnt_q == last_cnt;
        mem_final = (mode == e_pump_1toN) | is_last;
        fsm_v_o   = fifo_v & ((mode != e_pump_Nto1) | is_last);
        pop       = (mode == e_pump_1toN) ? fsm_yumi_i & is_last & fifo_last
                  : (mode == e_pump_Nto1 & !is_last) ? fifo_v : fsm_yumi_i;
        cnt_up    = (mode == e_pump_Nto1) ? fifo_v & !is_last : fsm_yumi_i & !is_last;
        stream_done_o = fsm_yumi_i & is_last;
        stream_new_o  = fsm_v_o & ((mode == e_pump_Nto1) | (state_q == e_pump_idle));
        // A popped mem_last always ends the message, which also resynchronises after an error.
        restart   = stream_done_o | (pop & fifo_last);
        err_d     = err_q | (pop & (fifo_last != mem_final));
        state_d   = restart ? e_pump_idle : cnt_up ? e_pump_stream : state_q;
        cnt_d     = restart ? '0 : cnt_up ? cnt_q + 1'b1 : cnt_q;
        hdr_d     = (state_q == e_pump_idle & cnt_up) ? fifo_hdr : hdr_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_pump_idle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            hdr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            hdr_q   <= hdr_d;
        end
    end

    assign fsm_base_header_o = cur_hdr;
    assign fsm_cnt_o         = cnt_q;
    assign error_o           = err_q;

    bp_me_stream_wraparound #(
        .paddr_width_p  (paddr_width_gp),
        .stream_offset_p(stream_offset_lp),
        .cnt_width_p    (cnt_width_lp)
    ) wrap (
        .base_addr_i(cur_hdr.addr),
        .cnt_i      (cnt_q),
        .last_cnt_i (last_cnt),
        .wrap_i     (wrap_mode_p != 0),
        .addr_o     (fsm_addr_o)
    );

endmodule

// File: tb/tb_bp_me_stream_pump_in_gen.sv
// tb_bp_me_stream_pump_in_gen: directed scenarios on a wrap-mode pump and a linear-mode twin fed the same stimulus.
module tb_bp_me_stream_pump_in_gen;
    import bp_me_pkg::*;

    logic clk = 1'b0;
    logic reset_i, mem_v_i, mem_last_i, fsm_yumi_i;
    bp_bedrock_mem_header_s mem_header_i, hdr_o, hdr_l;
    logic [63:0] mem_data_i, data_o, data_l;
    logic [39:0] addr_o, addr_l;
    logic [2:0] cnt_o, cnt_l;
    logic ready_o, v_o, new_o, done_o, err_o;
    logic ready_l, v_l, new_l, done_l, err_l;
    int checks = 0, passes = 0;

    always #5 clk = ~clk;

    // rd: 1:N, wr: N:N, uc_wr: N:1
    bp_me_stream_pump_in_gen #(
        .fifo_els_p(4), .mem_stream_mask_p('hA), .fsm_stream_mask_p('h3), .wrap_mode_p(1)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .mem_header_i(mem_header_i), .mem_data_i(mem_data_i),
        .mem_v_i(mem_v_i), .mem_last_i(mem_last_i), .mem_ready_and_o(ready_o),
        .fsm_base_header_o(hdr_o), .fsm_addr_o(addr_o), .fsm_data_o(data_o), .fsm_v_o(v_o),
        .fsm_yumi_i(fsm_yumi_i), .fsm_cnt_o(cnt_o), .stream_new_o(new_o), .stream_done_o(done_o),
        .error_o(err_o)
    );

    bp_me_stream_pump_in_gen #(
        .fifo_els_p(4), .mem_stream_mask_p('hA), .fsm_stream_mask_p('h3), .wrap_mode_p(0)
    ) dut_lin (
        .clk_i(clk), .reset_i(reset_i), .mem_header_i(mem_header_i), .mem_data_i(mem_data_i),
        .mem_v_i(mem_v_i), .mem_last_i(mem_last_i), .mem_ready_and_o(ready_l),
        .fsm_base_header_o(hdr_l), .fsm_addr_o(addr_l), .fsm_data_o(data_l), .fsm_v_o(v_l),
        .fsm_yumi_i(fsm_yumi_i), .fsm_cnt_o(cnt_l), .stream_new_o(new_l), .stream_done_o(done_l),
        .error_o(err_l)
    );

    function automatic bp_bedrock_mem_header_s mk_hdr(input bp_bedrock_mem_type_e t, input bp_bedrock_msg_size_e s, input logic [39:0] a);
        mk_hdr = '0;
        mk_hdr.msg_type = t;
        mk_hdr.size = s;
        mk_hdr.addr = a;
    endfunction

    task automatic drive(input bp_bedrock_mem_header_s h, input logic [63:0] d, input logic l);
        mem_header_i = h;
        mem_data_i = d;
        mem_last_i = l;
        mem_v_i = 1'b1;
    endtask

    task automatic test_reset;
        reset_i = 1'b1; mem_v_i = 1'b0; fsm_yumi_i = 1'b0;
        mem_header_i = '0; mem_data_i = '0; mem_last_i = 1'b0;
        repeat (3) @(negedge clk);
        reset_i = 1'b0; #1;
        checks++; if (v_o !== 1'b0) $display("FAIL reset_v: got %b want 0", v_o); else passes++;
        checks++; if (cnt_o !== 3'd0) $display("FAIL reset_cnt: got %0d want 0", cnt_o); else passes++;
        checks++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", err_o); else passes++;
        checks++; if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready_o); else passes++;
    endtask

    task automatic test_1toN_wrap_linear;
        logic [7:0] exp_wrap [8] = '{8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'h00, 8'h08};
        @(negedge clk); drive(mk_hdr(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h1010), 64'hD00D, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); mem_v_i = 1'b0; fsm_yumi_i = 1'b1; #1;
            checks++; if (v_o !== 1'b1) $display("FAIL wrap_v beat %0d: got %b want 1", k, v_o); else passes++;
            checks++; if (addr_o[7:0] !== exp_wrap[k]) $display("FAIL wrap_addr beat %0d: got %h want %h", k, addr_o[7:0], exp_wrap[k]); else passes++;
            checks++; if (addr_l[7:0] !== 8'(k * 8)) $display("FAIL lin_addr beat %0d: got %h want %h", k, addr_l[7:0], 8'(k * 8)); else passes++;
            checks++; if (cnt_o !== 3'(k)) $display("FAIL wrap_cnt beat %0d: got %0d want %0d", k, cnt_o, k); else passes++;
            checks++; if (new_o !== (k == 0)) $display("FAIL wrap_new beat %0d: got %b want %b", k, new_o, k == 0); else passes++;
            checks++; if (done_o !== (k == 7)) $display("FAIL wrap_done beat %0d: got %b want %b", k, done_o, k == 7); else passes++;
            checks++; if (data_o !== 64'hD00D) $display("FAIL wrap_data beat %0d: got %h want d00d", k, data_o); else passes++;
            if (k == 3) begin
                checks++; if (hdr_l.addr !== 40'h1010) $display("FAIL lin_hdr_addr: got %h want 1010", hdr_l.addr); else passes++;
                checks++; if (hdr_o.addr !== 40'h1010) $display("FAIL wrap_hdr_addr: got %h want 1010", hdr_o.addr); else passes++;
            end
        end
        @(negedge clk); fsm_yumi_i = 1'b0; #1;
        checks++; if (v_o !== 1'b0) $display("FAIL wrap_single_pop: got v=%b want 0", v_o); else passes++;
    endtask

    task automatic test_nn_stall;
        int dones = 0;
        logic [2:0] exp_cnt [7] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3};
        logic yumi [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); drive(mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_32, 40'h2000), 64'hA0 + 64'(k), k == 3); #1;
            checks++; if (ready_o !== 1'b1) $display("FAIL nn_ready beat %0d: got %b want 1", k, ready_o); else passes++;
        end
        @(negedge clk); mem_v_i = 1'b0; #1;
        checks++; if (ready_o !== 1'b0) $display("FAIL nn_full: got ready %b want 0", ready_o); else passes++;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            fsm_yumi_i = yumi[c]; #1;
            checks++; if (v_o !== 1'b1) $display("FAIL nn_v cyc %0d: got %b want 1", c, v_o); else passes++;
            checks++; if (data_o !== 64'hA0 + 64'(exp_cnt[c])) $display("FAIL nn_data cyc %0d: got %h want %h", c, data_o, 64'hA0 + 64'(exp_cnt[c])); else passes++;
            checks++; if (cnt_o !== exp_cnt[c]) $display("FAIL nn_cnt cyc %0d: got %0d want %0d", c, cnt_o, exp_cnt[c]); else passes++;
            checks++; if (addr_o !== 40'h2000 + 40'(exp_cnt[c]) * 8) $display("FAIL nn_addr cyc %0d: got %h want %h", c, addr_o, 40'h2000 + 40'(exp_cnt[c]) * 8); else passes++;
            if (done_o) dones++;
        end
        @(negedge clk); fsm_yumi_i = 1'b0; #1;
        checks++; if (v_o !== 1'b0) $display("FAIL nn_drain: got v=%b want 0", v_o); else passes++;
        checks++; if (dones != 1) $display("FAIL nn_done_count: got %0d want 1", dones); else passes++;
    endtask

    task automatic test_nto1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); drive(mk_hdr(e_bedrock_mem_uc_wr, e_bedrock_msg_size_64, 40'h4000), 64'hB0 + 64'(k), k == 7); #1;
            checks++; if (v_o !== 1'b0) $display("FAIL nto1_silent cyc %0d: got v=%b want 0", k, v_o); else passes++;
        end
        @(negedge clk); mem_v_i = 1'b0; fsm_yumi_i = 1'b1; #1;
        checks++; if (v_o !== 1'b1) $display("FAIL nto1_v: got %b want 1", v_o); else passes++;
        checks++; if (data_o !== 64'hB7) $display("FAIL nto1_data: got %h want b7", data_o); else passes++;
        checks++; if ({new_o, done_o} !== 2'b11) $display("FAIL nto1_new_done: got %b want 11", {new_o, done_o}); else passes++;
        @(negedge clk); fsm_yumi_i = 1'b0; #1;
        checks++; if (v_o !== 1'b0) $display("FAIL nto1_drain: got v=%b want 0", v_o); else passes++;
        checks++; if (err_o !== 1'b0) $display("FAIL nto1_err: got %b want 0", err_o); else passes++;
    endtask

    task automatic test_protocol_error;
        @(negedge clk); drive(mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_32, 40'h3000), 64'hC0, 1'b0);
        @(negedge clk); drive(mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_32, 40'h3000), 64'hC1, 1'b1);
        @(negedge clk); mem_v_i = 1'b0; fsm_yumi_i = 1'b1; #1;
        checks++; if (err_o !== 1'b0) $display("FAIL perr_pre0: got %b want 0", err_o); else passes++;
        @(negedge clk); #1;
        checks++; if (err_o !== 1'b0) $display("FAIL perr_pre1: got %b want 0", err_o); else passes++;
        checks++; if (done_o !== 1'b0) $display("FAIL perr_done: got %b want 0", done_o); else passes++;
        @(negedge clk); fsm_yumi_i = 1'b0; #1;
        checks++; if (err_o !== 1'b1) $display("FAIL perr_set: got %b want 1", err_o); else passes++;
        checks++; if (cnt_o !== 3'd0) $display("FAIL perr_resync_cnt: got %0d want 0", cnt_o); else passes++;
        @(negedge clk); drive(mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_8, 40'h3008), 64'hC8, 1'b1);
        @(negedge clk); mem_v_i = 1'b0; fsm_yumi_i = 1'b1; #1;
        checks++; if ({v_o, new_o, done_o} !== 3'b111) $display("FAIL perr_next_msg: got %b want 111", {v_o, new_o, done_o}); else passes++;
        checks++; if (data_o !== 64'hC8) $display("FAIL perr_next_data: got %h want c8", data_o); else passes++;
        @(negedge clk); fsm_yumi_i = 1'b0; #1;
        checks++; if (err_o !== 1'b1) $display("FAIL perr_sticky: got %b want 1", err_o); else passes++;
        checks++; if (v_o !== 1'b0) $display("FAIL perr_drain: got v=%b want 0", v_o); else passes++;
    endtask

    task automatic test_reset_midstream;
        @(negedge clk); drive(mk_hdr(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h40), 64'hE0, 1'b1);
        @(negedge clk); mem_v_i = 1'b0; fsm_yumi_i = 1'b1;
        repeat (2) @(negedge clk);
        @(negedge clk); fsm_yumi_i = 1'b0; reset_i = 1'b1; #1;
        checks++; if (cnt_o !== 3'd3) $display("FAIL mid_cnt_before: got %0d want 3", cnt_o); else passes++;
        @(negedge clk); reset_i = 1'b0; #1;
        checks++; if (v_o !== 1'b0) $display("FAIL mid_v: got %b want 0", v_o); else passes++;
        checks++; if (cnt_o !== 3'd0) $display("FAIL mid_cnt: got %0d want 0", cnt_o); else passes++;
        checks++; if (err_o !== 1'b0) $display("FAIL mid_err: got %b want 0", err_o); else passes++;
        @(negedge clk); drive(mk_hdr(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h1010), 64'hE1, 1'b1);
        @(negedge clk); mem_v_i = 1'b0; #1;
        checks++; if ({v_o, new_o} !== 2'b11) $display("FAIL mid_fresh_new: got %b want 11", {v_o, new_o}); else passes++;
        checks++; if (cnt_o !== 3'd0) $display("FAIL mid_fresh_cnt: got %0d want 0", cnt_o); else passes++;
        checks++; if (addr_o[7:0] !== 8'h10) $display("FAIL mid_fresh_addr: got %h want 10", addr_o[7:0]); else passes++;
    endtask

    initial begin
        test_reset;
        test_1toN_wrap_linear;
        test_nn_stall;
        test_nto1;
        test_protocol_error;
        test_reset_midstream;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bp_me_stream_pump_in_gen.md
Name: bp_me_stream_pump_in_gen

Overview:
- Generalised inbound BedRock Stream pump. Buffers one inbound mem stream channel in a parametrised-depth FIFO and presents per-beat header, address and data to a consumer FSM.
- Adds three things:
  - selectable address sequencing: wrap/critical-word-first or linear size-aligned.
  - an explicit beat-index output.
  - sticky protocol-error detection when mem_last disagrees with the header size.
- Sits between a mem stream link (network or CCE side) and a cache, device or CCE FSM. Supports 1:N, N:1 and N:N beat conversion.

Parameters:
- bp_params_p, e_bp_default_cfg: processor config; supplies paddr_width_p, lce_id_width_p, lce_assoc_p.
- stream_data_width_p, 64: beat width in bits; power of two, at least 64.
- block_width_p, 512: maximum message payload in bits; a multiple of stream_data_width_p.
- fifo_els_p, 2: input buffer depth. 2 uses a two-element FIFO; more than 2 uses a small 1r1w FIFO.
- mem_stream_mask_p, 0: msg_type bitmask of types that are multi-beat on the mem side.
- fsm_stream_mask_p, mem_stream_mask_p: msg_type bitmask of types that are multi-beat on the FSM side.
- wrap_mode_p, 1: 1 = wrap-around from the critical word; 0 = linear from the size-aligned base.
- Derived widths:
  - stream_words_lp = block_width_p / stream_data_width_p.
  - cnt_width_lp = clog2-safe(stream_words_lp).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- mem_header_i  in  mem header width  inbound BedRock mem header.
- mem_data_i  in  stream_data_width_p  inbound beat data.
- mem_v_i  in  1  inbound valid.
- mem_last_i  in  1  last beat of the inbound message.
- mem_ready_and_o  out  1  ready-and handshake; high whenever the FIFO is not full.
- fsm_base_header_o  out  mem header width  buffered header; addr low block-offset bits replaced by the latched critical address.
- fsm_addr_o  out  paddr_width_p  address of the current beat.
- fsm_data_o  out  stream_data_width_p  data of the current beat.
- fsm_v_o  out  1  beat valid to the FSM.
- fsm_yumi_i  in  1  FSM consumes the beat; legal only when fsm_v_o is high.
- fsm_cnt_o  out  cnt_width_lp  beat index within the message; 0 on the first beat.
- stream_new_o  out  1  high on the first FSM beat of every message.
- stream_done_o  out  1  equals fsm_yumi_i AND the current beat is the final FSM beat.
- error_o  out  1  sticky protocol error.

Behaviour:
- Reset: FIFO is empty, so fsm_v_o = 0. The counter, streaming flag and error_o are 0. mem_ready_and_o is 1 on the first cycle after reset deasserts.
- Latency: one cycle minimum from input handshake to fsm_v_o, with full throughput of one beat per cycle.
- Beat count: num_beats = max(2^size / (stream_data_width_p/8), 1).
- A message is multi-beat when num_beats > 1 and its msg_type bit is set in either mask.
- FSM states:
  - IDLE: first beat of a message. The critical address is taken combinationally (bypass) from the FIFO head.
  - STREAM: entered when a non-final beat is consumed (cnt_up). Left on stream_done_o.
  - Done has priority over cnt_up when both occur in the same cycle.
- Counter: beat index runs 0 to num_beats-1.
  - Wrap mode: address field = (critical index + count) modulo num_beats. Upper index bits come from the header; only the low log2(num_beats) bits change.
  - Linear mode: address field = count, inserted into the low log2(num_beats) bits. Bits below stream_offset keep the header value.
- 1:1 (N:N) conversion:
  - fsm_v_o = FIFO valid.
  - FIFO yumi = fsm_yumi_i.
- 1:N conversion (fsm mask only):
  - The FIFO head is held while beats are generated.
  - The FIFO is popped only on the final FSM beat, and only if the head has mem_last set.
- N:1 conversion (mem mask only):
  - Non-final mem beats are popped silently while the count advances.
  - fsm_v_o is raised only on the final beat.
  - stream_new_o is high with that single FSM beat.
- Single-beat messages assert stream_new_o and stream_done_o together, and fsm_cnt_o = 0.
- error_o is set (sticky until reset) when either:
  - a FIFO beat with mem_last = 1 is popped while the expected mem beat count is not final; or
  - a beat with mem_last = 0 is popped on the final expected mem beat.
  After setting error_o, the block resynchronises: it returns to IDLE whenever mem_last is popped.
- Reset mid-stream: everything returns to the reset state in the next cycle and any partially received message is discarded. Upstream must also reset.
- fsm_base_header_o is stable for the whole message. All outputs are combinational from FIFO and state registers only; there is no combinational path from mem_* inputs to fsm_* outputs.

Decomposition:
- Shared package (bp_me_pkg) holds the pump mode enum (e_pump_1to1, e_pump_1toN, e_pump_Nto1) and a function computing num_beats from size.
- One natural sub-module: bp_me_stream_wraparound, the combinational beat-address generator. Inputs are base address, beat count, num_beats and mode; output is the beat address.
- Standard bsg FIFO, counter and dff primitives are reused.

Test Plan:
- 1:N, wrap mode, 64B read, addr 0x1010: fsm_addr_o low bits 0x10, 0x18, 0x20, 0x28, 0x30, 0x38, 0x00, 0x08. stream_new_o on beat 0, stream_done_o on beat 7, a single FIFO pop, fsm_cnt_o 0 through 7.
- Same request with wrap_mode_p = 0: fsm_addr_o low bits 0x00, 0x08, ..., 0x38; the header address still reports 0x1010.
- N:N 32B write, 4 beats, fsm_yumi_i stalled 3 cycles on beat 1: data order preserved, no drops, stream_done_o exactly once, fifo_els_p = 4 absorbs a 4-beat burst.
- N:1 64B write: 7 silent pops, then fsm_v_o with the last data beat. stream_new_o and stream_done_o coincide.
- Protocol error: 32B message with mem_last on beat 1: error_o = 1 the next cycle and stays high. The next well-formed 8B message completes normally.
- Reset asserted on beat 3 of an 8-beat stream: the next cycle has fsm_v_o = 0 and fsm_cnt_o = 0. A fresh message after reset starts at beat 0.
